// File: rtl/uart_txer.sv
`default_nettype none
// ============================================================================
// Module   : uart_txer
// Purpose  : 8N1 UART transmitter with a small byte FIFO. Bytes arrive on a
//            one-cycle strobe, queue in a 2**FIFO_AW entry FIFO and leave
//            LSB first, framed by a start bit (0) and a stop bit (1). Frames
//            run back to back, with no idle gap, while the FIFO holds data.
// Options  : define UART_TXER_PARITY_EN to insert an even-parity bit between
//            the data bits and the stop bit (11-bit frame).
// Revision : 1.0 - initial release
// ============================================================================
module uart_txer #(
   parameter int BIT_CYCLES = 5000,
   parameter int FIFO_AW    = 2
) (
   input  logic       clk,
   input  logic       res,
   input  logic [7:0] data_in,
   input  logic       en_data_in,
   output logic       TX,
   output logic       full,
   output logic       busy,
   output logic       overflow
);

   localparam int               c_DEPTH     = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] c_DEPTH_CNT = (FIFO_AW + 1)'(c_DEPTH);
   localparam logic [15:0]      c_LAST      = 16'(BIT_CYCLES - 1);

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_START  = 3'd1;
   localparam logic [2:0] c_ST_DATA   = 3'd2;
   localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_TXER_PARITY_EN
   localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

   logic [7:0]         r_mem [c_DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_count;
   logic [2:0]         r_state;
   logic [15:0]        r_cnt;
   logic [2:0]         r_idx;
   logic [7:0]         r_sr;
   logic               r_tx;
   logic               r_full;
   logic               r_busy;
   logic               r_ovf;

   logic               w_empty;
   logic               w_bit_end;
   logic               w_pop;
   logic               w_wr;
   logic [FIFO_AW:0]   w_count_nxt;
   logic [2:0]         w_state_nxt;
   logic [15:0]        w_cnt_nxt;
   logic [2:0]         w_idx_nxt;
   logic               w_tx_nxt;

   assign w_empty   = (r_count == '0);
   assign w_bit_end = (r_cnt == c_LAST);
   // A byte leaves the FIFO only when a new frame starts: from IDLE, or at
   // the end of a stop bit so the next start bit follows with no gap.
   assign w_pop     = !w_empty && ((r_state == c_ST_IDLE) ||
                                   ((r_state == c_ST_STOP) && w_bit_end));
   // A pop on the same edge frees a slot, so a full FIFO still accepts.
   assign w_wr        = en_data_in && (!r_full || w_pop);
   assign w_count_nxt = r_count + (FIFO_AW + 1)'(w_wr) - (FIFO_AW + 1)'(w_pop);

   // Frame sequencing: bit timer, data bit index and state transitions
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 16'd1;
      w_idx_nxt   = r_idx;
      case (r_state)
         c_ST_IDLE: begin
            w_cnt_nxt = '0;
            if (!w_empty) w_state_nxt = c_ST_START;
         end
         c_ST_START: begin
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = c_ST_DATA;
            end
         end
         c_ST_DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               if (r_idx == 3'd7) begin
`ifdef UART_TXER_PARITY_EN
                  w_state_nxt = c_ST_PARITY;
`else
                  w_state_nxt = c_ST_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
`ifdef UART_TXER_PARITY_EN
         c_ST_PARITY: begin
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_state_nxt = c_ST_STOP;
            end
         end
`endif
         c_ST_STOP: begin
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_state_nxt = w_empty ? c_ST_IDLE : c_ST_START;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // Line level derived from the current state; registered, so TX trails
   // the state by one clock while every bit still lasts BIT_CYCLES clocks
   always_comb begin
      w_tx_nxt = 1'b1;
      case (r_state)
         c_ST_START:  w_tx_nxt = 1'b0;
         c_ST_DATA:   w_tx_nxt = r_sr[r_idx];
`ifdef UART_TXER_PARITY_EN
         c_ST_PARITY: w_tx_nxt = ^r_sr;
`endif
         default:     w_tx_nxt = 1'b1;
      endcase
   end

   // FIFO storage: written only when the byte is accepted
   always_ff @(posedge clk) begin
      if (!res && w_wr) r_mem[r_wptr] <= data_in;
   end

   // Control state, FIFO bookkeeping and registered outputs
   always_ff @(posedge clk) begin
      if (res) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_state <= c_ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_sr    <= '0;
         r_tx    <= 1'b1;
         r_full  <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_sr   <= r_mem[r_rptr];
         end
         r_count <= w_count_nxt;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_tx    <= w_tx_nxt;
         r_full  <= (w_count_nxt == c_DEPTH_CNT);
         r_busy  <= (w_count_nxt != '0) || (w_state_nxt != c_ST_IDLE);
         r_ovf   <= en_data_in && r_full && !w_pop;
      end
   end

   assign TX       = r_tx;
   assign full     = r_full;
   assign busy     = r_busy;
   assign overflow = r_ovf;

endmodule
`default_nettype wire
